// File: rtl/laser_link_ctrl.sv
// laser_link_ctrl: FTDI-queue <-> laser link controller with echo, bridge, rx-only and constant modes.
// Optional build macro LASER_LINK_STATS_EN adds saturating tx/rx/drop statistics counters.
module laser_link_ctrl #(
    parameter int                DATA_W      = 8,
    parameter int                TIMEOUT_CYC = 4096,
    parameter logic [DATA_W-1:0] PATTERN     = DATA_W'(8'h0A),
    parameter int                CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              rdq_empty,
    input  logic [DATA_W-1:0] rdq_data,
    output logic              rdreq,
    input  logic              wrq_full,
    output logic              wrreq,
    output logic [DATA_W-1:0] wrq_data,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              clear_err,
    output logic              busy,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  tx_count,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_TX_START = 2'd2;
    localparam logic [1:0] ST_TX_WAIT  = 2'd3;

    localparam logic [1:0] MODE_ECHO    = 2'd0;
    localparam logic [1:0] MODE_BRIDGE  = 2'd1;
    localparam logic [1:0] MODE_RX_ONLY = 2'd2;
    localparam logic [1:0] MODE_CONST   = 2'd3;

    localparam int              TMR_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [1:0]        mode_q_r;
    logic [1:0]        mode_eff_s;
    logic [DATA_W-1:0] tx_data_r;
    logic [TMR_W-1:0]  timer_r;
    logic [TMR_W-1:0]  timer_inc_s;
    logic              err_timeout_r;
    logic              tx_start_r;
    logic              busy_r;
    logic [DATA_W-1:0] wr_hold_r;

    logic              fsm_rdreq_s;
    logic              echo_push_s;
    logic              load_rdq_s;
    logic              load_pat_s;
    logic              timeout_s;
    logic              rx_en_s;
    logic              rx_push_s;
    logic              wr_any_s;
    logic [DATA_W-1:0] wr_src_s;

    // Mode used for decisions: the live input while idle, the latched copy during a transaction.
    always_comb begin
        if (state_r == ST_IDLE) begin
            mode_eff_s = mode;
        end else begin
            mode_eff_s = mode_q_r;
        end
    end

    // The timeout fires in the cycle the timer would reach its last value.
    assign timer_inc_s = timer_r + TMR_W'(1);

    // Next-state logic and read-queue / transmitter handshakes.
    always_comb begin
        state_nxt_s = state_r;
        fsm_rdreq_s = 1'b0;
        echo_push_s = 1'b0;
        load_rdq_s  = 1'b0;
        load_pat_s  = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!en) begin
                    state_nxt_s = ST_IDLE;
                end else if ((mode_eff_s == MODE_ECHO) && !rdq_empty && !wrq_full) begin
                    fsm_rdreq_s = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else if ((mode_eff_s == MODE_BRIDGE) && !rdq_empty) begin
                    fsm_rdreq_s = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else if (mode_eff_s == MODE_CONST) begin
                    load_pat_s  = 1'b1;
                    state_nxt_s = ST_TX_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mode_eff_s == MODE_ECHO) begin
                    echo_push_s = !wrq_full;
                    if (en && !rdq_empty && !wrq_full) begin
                        fsm_rdreq_s = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    load_rdq_s  = 1'b1;
                    state_nxt_s = ST_TX_START;
                end
            end
            ST_TX_START: begin
                state_nxt_s = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (tx_done) begin
                    if (mode_eff_s == MODE_CONST) begin
                        if (en && (mode == mode_q_r)) begin
                            load_pat_s  = 1'b1;
                            state_nxt_s = ST_TX_START;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else if (en && !rdq_empty) begin
                        fsm_rdreq_s = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (timer_inc_s == TMR_LAST) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_TX_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // The RX path runs beside the FSM and never stalls; echo mode ignores it.
    assign rx_en_s   = (mode_eff_s == MODE_BRIDGE) || (mode_eff_s == MODE_RX_ONLY);
    assign rx_push_s = rx_en_s && rx_valid && !wrq_full;
    assign wr_any_s  = echo_push_s || rx_push_s;
    assign wr_src_s  = echo_push_s ? rdq_data : rx_data;

    // Strobes are gated by reset_n so nothing leaks out while reset is held.
    assign rdreq    = reset_n && fsm_rdreq_s;
    assign wrreq    = reset_n && wr_any_s;
    assign wrq_data = wrreq ? wr_src_s : wr_hold_r;

    // Control state, transmit word, timer and sticky timeout flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            mode_q_r      <= MODE_ECHO;
            tx_data_r     <= {DATA_W{1'b0}};
            timer_r       <= {TMR_W{1'b0}};
            err_timeout_r <= 1'b0;
            tx_start_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tx_start_r <= (state_nxt_s == ST_TX_START);
            busy_r     <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_IDLE) begin
                mode_q_r <= mode;
            end else begin
                mode_q_r <= mode_q_r;
            end
            if (load_rdq_s) begin
                tx_data_r <= rdq_data;
            end else if (load_pat_s) begin
                tx_data_r <= PATTERN;
            end else begin
                tx_data_r <= tx_data_r;
            end
            if (state_r == ST_TX_START) begin
                timer_r <= {TMR_W{1'b0}};
            end else if (state_r == ST_TX_WAIT) begin
                timer_r <= timer_inc_s;
            end else begin
                timer_r <= timer_r;
            end
            // A new timeout outranks a simultaneous clear.
            if (timeout_s) begin
                err_timeout_r <= 1'b1;
            end else if (clear_err) begin
                err_timeout_r <= 1'b0;
            end else begin
                err_timeout_r <= err_timeout_r;
            end
        end
    end

    // Last pushed word, presented on wrq_data while wrreq is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_hold_r <= {DATA_W{1'b0}};
        end else if (wr_any_s) begin
            wr_hold_r <= wr_src_s;
        end else begin
            wr_hold_r <= wr_hold_r;
        end
    end

    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign busy        = busy_r;
    assign err_timeout = err_timeout_r;

`ifdef LASER_LINK_STATS_EN
    logic             tx_ok_s;
    logic             rx_drop_s;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [CNT_W-1:0] drop_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end else begin
            return v;
        end
    endfunction

    assign tx_ok_s   = (state_r == ST_TX_WAIT) && tx_done;
    assign rx_drop_s = rx_en_s && rx_valid && wrq_full;

    // Saturating statistics counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_cnt_r   <= {CNT_W{1'b0}};
            rx_cnt_r   <= {CNT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tx_cnt_r   <= sat_inc(tx_cnt_r, tx_ok_s);
            rx_cnt_r   <= sat_inc(rx_cnt_r, rx_push_s);
            drop_cnt_r <= sat_inc(drop_cnt_r, rx_drop_s);
        end
    end

    assign tx_count   = tx_cnt_r;
    assign rx_count   = rx_cnt_r;
    assign drop_count = drop_cnt_r;
`else
    assign tx_count   = {CNT_W{1'b0}};
    assign rx_count   = {CNT_W{1'b0}};
    assign drop_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/laser_link_ctrl.md
Name: laser_link_ctrl

Overview:
Parametrised host-to-laser link controller and the successor to the fixed 8-bit echo controller. It sits between the FTDI interface queues (read queue = host→FPGA, write queue = FPGA→host) and the laser transmitter and receiver. It supports four run-time modes: echo, bridge, receive-only and constant-pattern transmit. Over the previous generation it adds a transmit-completion timeout, a receive-overflow policy and saturating statistics counters.

Parameters:
DATA_W, 8, byte/word width on all data paths
TIMEOUT_CYC, 4096, clock cycles allowed between tx_start and tx_done before timeout
PATTERN, 8'h0A (zero-extended to DATA_W), word sent in constant mode
CNT_W, 16, statistics counter width

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
en  in  1  allows new transactions to start from IDLE
mode  in  2  0=ECHO, 1=BRIDGE, 2=RX_ONLY, 3=CONSTANT
rdq_empty  in  1  read queue empty
rdq_data  in  DATA_W  read-queue word, valid the cycle after rdreq
rdreq  out  1  read-queue pop
wrq_full  in  1  write queue full
wrreq  out  1  write-queue push
wrq_data  out  DATA_W  write-queue word
tx_start  out  1  one-cycle start pulse to the transmitter
tx_data  out  DATA_W  registered transmit word
tx_done  in  1  transmitter finished the current word
rx_valid  in  1  one-cycle strobe: received word valid
rx_data  in  DATA_W  received word
clear_err  in  1  clears err_timeout
busy  out  1  state != IDLE
err_timeout  out  1  sticky timeout flag
tx_count, rx_count, drop_count  out  CNT_W  statistics

Behaviour:
- Reset: state=IDLE; mode_q=0; tx_data=0; timer=0; err_timeout=0; all counters=0; rdreq, wrreq, tx_start=0; wrq_data=0.
- mode is latched into mode_q only in IDLE. A mode change mid-transaction takes effect after the controller returns to IDLE.
- en low: IDLE starts nothing. An in-flight transaction still completes.
- States: IDLE, FETCH, TX_START, TX_WAIT.
- ECHO:
  - IDLE: if en & !rdq_empty & !wrq_full, then rdreq=1 and go to FETCH.
  - FETCH: wrreq=1, wrq_data=rdq_data. If en & !rdq_empty & !wrq_full, then rdreq=1 and stay in FETCH; else go to IDLE.
  - Sustained throughput is 1 word/cycle. rx_valid is ignored and does not count as a drop.
- BRIDGE:
  - IDLE: if en & !rdq_empty, then rdreq=1 and go to FETCH.
  - FETCH: tx_data<=rdq_data; go to TX_START.
  - TX_START: tx_start=1 for exactly one cycle; timer<=0; go to TX_WAIT.
  - TX_WAIT, tx_done=1: tx_count++. If en & !rdq_empty, then rdreq=1 and go to FETCH; else go to IDLE.
  - TX_WAIT, timer reaches TIMEOUT_CYC-1 without tx_done: err_timeout<=1; go to IDLE. The word is not counted.
  - Latency: rdreq → tx_start is 2 cycles.
- RX path (BRIDGE and RX_ONLY), independent of the state machine:
  - rx_valid & !wrq_full: wrreq=1, wrq_data=rx_data, rx_count++.
  - rx_valid & wrq_full: word dropped, drop_count++.
  - The RX path never stalls.
- RX_ONLY: the read queue is never popped; the state machine stays in IDLE.
- CONSTANT: the read queue is never popped.
  - IDLE with en: tx_data<=PATTERN; go to TX_START.
  - TX_START then TX_WAIT as in BRIDGE.
  - On tx_done, return to TX_START while en and mode are unchanged; on timeout, go to IDLE.
- wrreq is never asserted while wrq_full=1. wrq_data holds its last value when wrreq=0.
- tx_done outside TX_WAIT is ignored.
- tx_done and timeout expiry in the same cycle: tx_done wins and err_timeout is unchanged.
- clear_err and a new timeout in the same cycle: err_timeout stays 1 (set wins).
- Counters saturate at 2^CNT_W-1 and do not wrap.
- reset_n asserted mid-transaction: immediate return to reset values. No pulse on rdreq, wrreq or tx_start is completed.

Optional Feature:
LASER_LINK_STATS_EN
- Defined: tx_count, rx_count and drop_count are implemented as specified.
- Undefined: no counter registers are built; all three outputs are tied to 0. Drop behaviour is otherwise identical.

Test Plan:
- ECHO: load rdq with 0x11, 0x22, 0x33 and keep wrq not full → wrq receives 0x11, 0x22, 0x33 on 3 consecutive cycles; rdq is popped exactly 3 times; busy falls 1 cycle after the last push.
- BRIDGE: rdq holds 0xA5; tx_done is returned 10 cycles after tx_start → tx_start rises 2 cycles after rdreq with tx_data=0xA5; tx_count=1; back to IDLE.
- BRIDGE timeout with TIMEOUT_CYC=16 and tx_done never asserted → err_timeout=1 exactly 16 cycles after tx_start; state=IDLE; clear_err returns it to 0.
- RX overflow: wrq_full=1, three rx_valid strobes with 0x01..0x03, then wrq_full=0 and one strobe with 0x04 → drop_count=3, rx_count=1, only 0x04 is pushed.
- CONSTANT with tx_done pulsed every 8 cycles → repeated tx_start with tx_data=0x0A and rdreq never asserted. Switch mode to 1 mid-transmission → constant mode continues until the next IDLE entry, then bridge mode takes over.
- Reset in TX_WAIT (reset_n low for 1 cycle) → all outputs are 0 immediately; a tx_done after reset has no effect and tx_count stays 0.
